// File: rtl/i2c_target_regs.sv
// I2C/SMBus target with four control bytes and four status bytes, oversampled on sysclk.
// Standard mode only; SCL is never driven and SDA is only ever pulled low through sda_oe.
module i2c_target_regs #(
  parameter logic [6:0]  DEV_ADDR   = 7'h2A,
  parameter int unsigned FILT_LEN   = 3,
  parameter logic [31:0] CTRL_RESET = 32'h0000_0000
) (
  input  logic        sysclk,
  input  logic        reset_INV,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic [31:0] ctrl_out,
  input  logic [31:0] status_in,
  output logic        wr_strobe,
  output logic [1:0]  wr_index,
  output logic        busy
);

  localparam int unsigned CW = $clog2(FILT_LEN + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_PTR   = 3'd2,
    ST_WDATA = 3'd3,
    ST_RDATA = 3'd4,
    ST_WAIT  = 3'd5
  } state_t;

  // Line index 0 is SCL, 1 is SDA.
  logic [1:0]    sync1, sync2, filt;
  logic [CW-1:0] fcnt [2];
  logic [1:0]    accept;

  always_comb begin
    accept = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      accept[i] = (sync2[i] != filt[i]) && (fcnt[i] == CW'(FILT_LEN - 1));
    end
  end

  // A new level is taken on the FILT_LEN-th consecutive differing sample.
  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      sync1 <= '1;
      sync2 <= '1;
      filt  <= '1;
      for (int unsigned i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      sync1 <= {sda_in, scl_in};
      sync2 <= sync1;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] != filt[i]) begin
          if (accept[i]) begin
            filt[i] <= sync2[i];
            fcnt[i] <= '0;
          end else begin
            fcnt[i] <= fcnt[i] + CW'(1);
          end
        end else begin
          fcnt[i] <= '0;
        end
      end
    end
  end

  logic scl_rise, scl_fall, scl_edge, sda_level, start_c, stop_c;

  // An SCL edge in the same cycle as an SDA change masks the SDA change as a condition.
  always_comb begin
    scl_edge  = accept[0];
    scl_rise  = accept[0] & sync2[0];
    scl_fall  = accept[0] & ~sync2[0];
    sda_level = accept[1] ? sync2[1] : filt[1];
    start_c   = accept[1] & ~sync2[1] & ~scl_edge & filt[0];
    stop_c    = accept[1] &  sync2[1] & ~scl_edge & filt[0];
  end

  state_t      state, ack_next;
  logic [3:0]  bit_cnt;
  logic [6:0]  shreg;
  logic [6:0]  tx;
  logic [2:0]  pointer;
  logic        ack_en;
  logic        rw;
  logic [7:0]  rx_byte;
  logic [31:0] rd_sel;
  logic [7:0]  rd_byte;

  always_comb begin
    rx_byte = {shreg, sda_level};
    rd_sel  = pointer[2] ? status_in : ctrl_out;
    rd_byte = rd_sel[{pointer[1:0], 3'b000} +: 8];
    case (state)
      ST_ADDR: ack_next = rw ? ST_RDATA : ST_PTR;
      ST_PTR:  ack_next = ST_WDATA;
      default: ack_next = state;
    endcase
  end

  // bit_cnt counts SCL rises within a 9-clock frame; the fall after rise 8 opens the
  // ACK slot and the fall after rise 9 closes it.
  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      tx        <= '0;
      pointer   <= '0;
      ack_en    <= 1'b0;
      rw        <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      ctrl_out  <= CTRL_RESET;
      wr_strobe <= 1'b0;
      wr_index  <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (start_c) begin
        state   <= ST_ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        ack_en  <= 1'b0;
        busy    <= 1'b1;
      end else if (stop_c) begin
        state  <= ST_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (state != ST_IDLE && state != ST_WAIT) begin
        if (scl_rise) begin
          if (bit_cnt < 4'd8) begin
            shreg   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 4'd1;
          end else begin
            bit_cnt <= 4'd9;
          end
          if (bit_cnt == 4'd7) begin
            case (state)
              ST_ADDR: begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  ack_en <= 1'b1;
                  rw     <= rx_byte[0];
                end else begin
                  state <= ST_IDLE;
                end
              end
              ST_PTR: begin
                pointer <= rx_byte[2:0];
                ack_en  <= 1'b1;
              end
              ST_WDATA: begin
                ack_en <= 1'b1;
                if (!pointer[2]) begin
                  ctrl_out[{pointer[1:0], 3'b000} +: 8] <= rx_byte;
                  wr_strobe <= 1'b1;
                  wr_index  <= pointer[1:0];
                end
                pointer <= pointer + 3'd1;
              end
              default: ;
            endcase
          end
          if (bit_cnt == 4'd8 && state == ST_RDATA) begin
            pointer <= pointer + 3'd1;
            if (sda_level) state <= ST_WAIT;
          end
        end else if (scl_fall) begin
          if (bit_cnt == 4'd8) begin
            sda_oe <= ack_en;
          end else if (bit_cnt == 4'd9) begin
            bit_cnt <= '0;
            ack_en  <= 1'b0;
            state   <= ack_next;
            if (ack_next == ST_RDATA) begin
              tx     <= rd_byte[6:0];
              sda_oe <= ~rd_byte[7];
            end else begin
              sda_oe <= 1'b0;
            end
          end else if (state == ST_RDATA && bit_cnt != 4'd0) begin
            sda_oe <= ~tx[6];
            tx     <= {tx[5:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: a bit-banged I2C master with scoreboard queues for ACKs,
// read bytes and write strobes, plus a table of single-byte write transactions.
module tb_i2c_target_regs;

  localparam int Q = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scl_m, sda_m;
  logic        bus_sda;
  logic        sda_oe;
  logic [31:0] ctrl_out;
  logic [31:0] status_in;
  logic        wr_strobe;
  logic [1:0]  wr_index;
  logic        busy;

  always #5 clk = ~clk;

  assign bus_sda = sda_m & ~sda_oe;

  i2c_target_regs #(
    .DEV_ADDR  (7'h2A),
    .FILT_LEN  (3),
    .CTRL_RESET(32'h0000_0000)
  ) dut (
    .sysclk   (clk),
    .reset_INV(rst_n),
    .scl_in   (scl_m),
    .sda_in   (bus_sda),
    .sda_oe   (sda_oe),
    .ctrl_out (ctrl_out),
    .status_in(status_in),
    .wr_strobe(wr_strobe),
    .wr_index (wr_index),
    .busy     (busy)
  );

  int checks = 0;
  int errors = 0;

  logic       ack_q [$];
  logic [7:0] rd_q  [$];
  logic [9:0] stb_q [$];
  logic [7:0] wq    [$];
  logic [9:0] stb_e;
  logic       forbid_oe = 1'b0;
  int         oe_viol = 0;

  typedef struct {
    logic [2:0]  ptr;
    logic [7:0]  data;
    logic [31:0] exp_ctrl;
    logic        exp_strobe;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && wr_strobe) begin
      chk("strobe_expected", (stb_q.size() > 0), 1);
      if (stb_q.size() > 0) begin
        stb_e = stb_q.pop_front();
        chk("wr_index", wr_index, stb_e[9:8]);
        chk("wr_data", ctrl_out[{wr_index, 3'b000} +: 8], stb_e[7:0]);
      end
    end
    if (forbid_oe && sda_oe) oe_viol++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; cyc(Q);
    scl_m = 1'b1; cyc(Q);
    sda_m = 1'b0; cyc(Q);
    scl_m = 1'b0; cyc(Q);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; cyc(Q);
    scl_m = 1'b1; cyc(Q);
    sda_m = 1'b1; cyc(Q);
  endtask

  // Glitches: 1-cycle SCL low and (on a '1' bit) 2-cycle SDA low while SCL is high.
  task automatic clk_bit(input logic b, input logic glitch, output logic smp);
    sda_m = b; cyc(Q);
    scl_m = 1'b1; cyc(Q);
    smp = bus_sda;
    if (glitch) begin
      scl_m = 1'b0; cyc(1);
      scl_m = 1'b1; cyc(2);
      if (b) begin
        sda_m = 1'b0; cyc(2);
        sda_m = 1'b1;
      end
    end
    cyc(Q);
    scl_m = 1'b0; cyc(Q);
  endtask

  task automatic send_byte(input string nm, input logic [7:0] b, input logic exp_nack,
                           input logic glitch);
    logic s;
    ack_q.push_back(exp_nack);
    for (int i = 7; i >= 0; i--) clk_bit(b[i], glitch, s);
    clk_bit(1'b1, 1'b0, s);
    chk(nm, s, ack_q.pop_front());
  endtask

  task automatic read_byte(input logic [7:0] exp, input logic nack, input logic clobber);
    logic [7:0] got;
    logic s;
    rd_q.push_back(exp);
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, 1'b0, s);
      got[i] = s;
      if (clobber && i == 5) status_in = '0;
    end
    clk_bit(nack, 1'b0, s);
    chk("rd_byte", got, rd_q.pop_front());
  endtask

  task automatic wr_txn(input logic [2:0] p, input logic glitch, input logic [31:0] exp_ctrl);
    i2c_start;
    chk("busy_start", busy, 1);
    send_byte("ack_addr", 8'h54, 1'b0, glitch);
    send_byte("ack_ptr", {5'b10110, p}, 1'b0, glitch);
    foreach (wq[k]) send_byte("ack_data", wq[k], 1'b0, glitch);
    i2c_stop;
    chk("busy_stop", busy, 0);
    chk("ctrl_out", ctrl_out, exp_ctrl);
    chk("strobe_drain", stb_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic s;
    vecs[0] = '{3'd1, 8'hA5, 32'h0000_A500, 1'b1};
    vecs[1] = '{3'd0, 8'h3C, 32'h0000_A53C, 1'b1};
    vecs[2] = '{3'd3, 8'hF0, 32'hF000_A53C, 1'b1};
    vecs[3] = '{3'd5, 8'h77, 32'hF000_A53C, 1'b0};
    vecs[4] = '{3'd2, 8'h81, 32'hF081_A53C, 1'b1};
    vecs[5] = '{3'd7, 8'hFF, 32'hF081_A53C, 1'b0};

    rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; status_in = '0;
    cyc(3);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_ctrl", ctrl_out, 32'h0);
    chk("rst_strobe", wr_strobe, 0);
    chk("rst_index", wr_index, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    cyc(Q);

    for (int k = 0; k < 6; k++) begin
      wq.delete();
      wq.push_back(vecs[k].data);
      if (vecs[k].exp_strobe) stb_q.push_back({vecs[k].ptr[1:0], vecs[k].data});
      wr_txn(vecs[k].ptr, 1'b0, vecs[k].exp_ctrl);
    end

    // Burst from pointer 3 wraps through the status range back to control byte 0.
    wq.delete();
    wq.push_back(8'h11); wq.push_back(8'h22); wq.push_back(8'h33);
    wq.push_back(8'h44); wq.push_back(8'h55); wq.push_back(8'h66);
    stb_q.push_back({2'd3, 8'h11});
    stb_q.push_back({2'd0, 8'h66});
    wr_txn(3'd3, 1'b0, 32'h1181_A566);

    wq.delete();
    wq.push_back(8'h5A);
    stb_q.push_back({2'd2, 8'h5A});
    wr_txn(3'd2, 1'b1, 32'h115A_A566);

    // Read registers 4-7 after a repeated START; last byte NACKed.
    status_in = 32'hDEAD_BEEF;
    i2c_start;
    send_byte("ack_addr", 8'h54, 1'b0, 1'b0);
    send_byte("ack_ptr", 8'h04, 1'b0, 1'b0);
    i2c_start;
    chk("busy_sr", busy, 1);
    send_byte("ack_addr_rd", 8'h55, 1'b0, 1'b0);
    read_byte(8'hEF, 1'b0, 1'b0);
    read_byte(8'hBE, 1'b0, 1'b0);
    read_byte(8'hAD, 1'b0, 1'b0);
    read_byte(8'hDE, 1'b1, 1'b1);
    cyc(Q);
    chk("nack_release", sda_oe, 0);
    clk_bit(1'b1, 1'b0, s);
    chk("wait_bus_high", s, 1);
    i2c_stop;
    chk("busy_after_rd", busy, 0);

    // Pointer wrapped to 0: next read returns control byte 0.
    i2c_start;
    send_byte("ack_addr_rd2", 8'h55, 1'b0, 1'b0);
    read_byte(8'h66, 1'b1, 1'b0);
    i2c_stop;

    forbid_oe = 1'b1;
    oe_viol = 0;
    i2c_start;
    send_byte("nack_mismatch", 8'h56, 1'b1, 1'b0);
    send_byte("nack_ignored", 8'hFF, 1'b1, 1'b0);
    i2c_stop;
    forbid_oe = 1'b0;
    chk("mismatch_oe", oe_viol, 0);
    chk("mismatch_ctrl", ctrl_out, 32'h115A_A566);

    // A 2-cycle SDA dip with SCL high must not start a transfer.
    sda_m = 1'b0; cyc(2);
    sda_m = 1'b1; cyc(Q);
    chk("glitch_busy", busy, 0);
    scl_m = 1'b0; cyc(Q);
    send_byte("nack_no_start", 8'h54, 1'b1, 1'b0);
    i2c_stop;

    // Reset while the target is driving bit 7 (0) of control byte 0.
    i2c_start;
    send_byte("ack_addr", 8'h54, 1'b0, 1'b0);
    send_byte("ack_ptr", 8'h00, 1'b0, 1'b0);
    i2c_start;
    send_byte("ack_addr_rd3", 8'h55, 1'b0, 1'b0);
    chk("drive_zero", sda_oe, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_oe", sda_oe, 0);
    chk("rst_mid_ctrl", ctrl_out, 32'h0);
    chk("rst_mid_busy", busy, 0);
    cyc(2);
    rst_n = 1'b1;
    sda_m = 1'b1;
    scl_m = 1'b1;
    cyc(Q);

    wq.delete();
    wq.push_back(8'hC3);
    stb_q.push_back({2'd1, 8'hC3});
    wr_txn(3'd1, 1'b0, 32'h0000_C300);

    cyc(Q);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
